// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and register-number width shared by the multiply/divide unit
package mdu_pkg;
  localparam int REG_W = 5;
  typedef logic [1:0] op_t;
  localparam op_t OP_MUL   = 2'b00;
  localparam op_t OP_MULHU = 2'b01;
  localparam op_t OP_DIVU  = 2'b10;
  localparam op_t OP_REMU  = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: one restoring-division step; shifts the next dividend bit into the partial remainder
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH-1:0] diff;
  logic ge;
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    ge = shifted >= {1'b0, div_i};
    // when ge the true difference fits in WIDTH bits, so the wrapped low bits are exact
    diff = shifted[WIDTH-1:0] - div_i;
    rem_o = ge ? diff : shifted[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle.
// Define MDU_DIVIDE_EN to build the divider; otherwise divide ops finish at once with err=1.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [REG_W-1:0] dest_reg,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [REG_W-1:0] result_reg,
  output logic             err
);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_nxt;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [WIDTH:0] mul_sum;
  op_t op_q, op_d;
  logic [REG_W-1:0] reg_q, reg_d;
  logic err_q, err_d;
`ifdef MDU_DIVIDE_EN
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .rem_i(acc_q[2*WIDTH-1:WIDTH]),
    .quo_i(acc_q[WIDTH-1:0]),
    .div_i(b_q),
    .rem_o(rem_nxt),
    .quo_o(quo_nxt)
  );
`endif
  // acc holds {product hi, multiplier} for multiply and {remainder, quotient} for divide,
  // so both results are picked from the same halves
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    reg_d = reg_q;
    err_d = err_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: if (start) begin
        a_d = operand_a;
        b_d = operand_b;
        op_d = op;
        reg_d = dest_reg;
        err_d = 1'b0;
        cnt_d = '0;
        acc_d = {{WIDTH{1'b0}}, op[1] ? operand_a : operand_b};
        state_d = ST_RUN;
`ifndef MDU_DIVIDE_EN
        if (op[1]) begin
          state_d = ST_DONE;
          result_d = '0;
          err_d = 1'b1;
        end
`endif
      end
      ST_RUN: if (cnt_q == CNT_W'(WIDTH)) begin
        state_d = ST_DONE;
        result_d = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        err_d = op_q[1] & ~|b_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIVIDE_EN
        acc_d = op_q[1] ? {rem_nxt, quo_nxt} : mul_nxt;
`else
        acc_d = mul_nxt;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= OP_MUL;
      reg_q <= '0;
      err_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      reg_q <= reg_d;
      err_q <= err_d;
      result_q <= result_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  assign result = result_q;
  assign result_reg = reg_q;
  assign err = err_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed ops checked against an arithmetic reference model
module tb_mult_div_unit;
  import mdu_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] operand_a = '0, operand_b = '0;
  logic [4:0] dest_reg = '0;
  logic busy, done, err;
  logic [W-1:0] result;
  logic [4:0] result_reg;
  int checks = 0;
  int failures = 0;
  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .busy(busy), .done(done), .result(result), .result_reg(result_reg), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] model_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (o == OP_MUL) return p[31:0];
    if (o == OP_MULHU) return p[63:32];
`ifdef MDU_DIVIDE_EN
    if (o == OP_DIVU) return (b == 0) ? '1 : a / b;
    return (b == 0) ? a : a % b;
`else
    return '0;
`endif
  endfunction
  function automatic logic model_err(input logic [1:0] o, input logic [W-1:0] b);
`ifdef MDU_DIVIDE_EN
    return o[1] && (b == 0);
`else
    return o[1];
`endif
  endfunction
  function automatic int model_lat(input logic [1:0] o);
`ifdef MDU_DIVIDE_EN
    return W + 1;
`else
    return o[1] ? 0 : W + 1;
`endif
  endfunction
  task automatic wait_done(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] d);
    int e = 0;
    chk("busy_after_accept", 64'(busy), 64'(1));
    while (!done && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    chk("latency", 64'(e), 64'(model_lat(o)));
    chk("result", 64'(result), 64'(model_res(o, a, b)));
    chk("result_reg", 64'(result_reg), 64'(d));
    chk("err", 64'(err), 64'(model_err(o, b)));
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] d, input bit hold);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
    @(posedge clk); #1;
    start = hold;
    op = 2'($urandom); operand_a = $urandom; operand_b = $urandom; dest_reg = 5'($urandom);
    wait_done(o, a, b, d);
  endtask
  initial begin
    int pulses;
    logic [W-1:0] ra, rb;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_reg", 64'(result_reg), 64'(0));
    @(negedge clk); reset = 1'b1;
    issue(OP_MUL, 32'd7, 32'd9, 5'd5, 1'b0);
    @(negedge clk);
    start = 1'b1; op = OP_MUL; operand_a = 32'd7; operand_b = 32'd9; dest_reg = 5'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3; reset = 1'b0; #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_reg", 64'(result_reg), 64'(0));
    @(negedge clk); @(negedge clk); reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'(0));
    issue(OP_MUL, 32'd7, 32'd9, 5'd5, 1'b0);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 1'b0);
    issue(OP_REMU, 32'd100, 32'd7, 5'd4, 1'b0);
    issue(OP_DIVU, 32'd42, 32'd0, 5'd6, 1'b0);
    issue(OP_REMU, 32'd42, 32'd0, 5'd7, 1'b0);
    issue(OP_DIVU, 32'd5, 32'd9, 5'd8, 1'b0);
    issue(OP_MUL, 32'd3, 32'd5, 5'd9, 1'b1);
    op = OP_MULHU; operand_a = 32'h8000_0001; operand_b = 32'h0000_0003; dest_reg = 5'd10;
    @(posedge clk); #1; start = 1'b0;
    wait_done(OP_MULHU, 32'h8000_0001, 32'h0000_0003, 5'd10);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 7 == 0) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      issue(2'($urandom), ra, rb, 5'($urandom), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
